// File: rtl/dialer_digit_collector_pkg.sv
// Shared definitions for the rotary-dialer digit collector.
// Holds the counting-mode selectors, the collector FSM encoding and the
// decimal "ten pulses means zero" code.
package dialer_digit_collector_pkg;

  localparam int MODE_FACT     = 0;   // digit k legal 0..k+1, wraps past k+1
  localparam int MODE_DEC      = 1;   // digit legal 0..9, ten pulses dial a 0
  localparam int DEC_ZERO_CODE = 10;  // raw pulse count that represents "0"

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // number complete or nothing dialed yet
    S_DIAL = 2'd1,  // dial off rest, pulses being counted
    S_GAP  = 2'd2   // between digits, inter-digit timeout running
  } state_t;

endpackage

// File: rtl/debounced_button.sv
// Purpose: synchronise and debounce one slow mechanical contact.
// Latency: 2 sync cycles + 2^CNT_MSB stable cycles + 1 before btn_out follows.
// Backpressure: none; free-running level filter.
// Ports: clk, reset (sync, active-high), btn_in (raw async), btn_out (clean level).
module debounced_button #(
  parameter int   CNT_MSB = 19,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out
);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_MSB:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  always_comb begin
    sync_d = {sync_q[0], btn_in};
    cnt_d  = '0;
    out_d  = out_q;
    // Any cycle where the input agrees with the output restarts the count,
    // so only an uninterrupted run of the new level is accepted.
    if (sync_q[1] != out_q) begin
      if (cnt_q[CNT_MSB]) begin
        out_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {2{RST_VAL}};
      cnt_q  <= '0;
      out_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign btn_out = out_q;

endmodule

// File: rtl/dialer_digit_collector_pulse_filter.sv
// Purpose: turn the bouncing dial pulse contact into one strobe per real pulse.
// Latency: 2 sync cycles + 1 registered strobe cycle after the contact closes.
// Backpressure: none; strobes are single-cycle and cannot be stalled.
// Ports: clk, reset (sync, active-high), pulse_in (raw async), gap_clr (zero
//        the gap counter), deb_pulse (1-cycle pulse per accepted dial pulse).
module dialer_pulse_filter #(
  parameter int PULSE_MSB = 22,
  parameter int PULSE_DLY = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  input  logic gap_clr,
  output logic deb_pulse
);

  logic [1:0]         sync_q, sync_d;
  logic [PULSE_MSB:0] gap_q, gap_d;
  logic               deb_q, deb_d;
  logic               is_real;

  // A closure only counts if the contact was open long enough before it;
  // contact chatter re-closes within the short window and is ignored.
  assign is_real = |gap_q[PULSE_MSB:PULSE_DLY];

  always_comb begin
    sync_d = {sync_q[0], pulse_in};
    gap_d  = gap_q;
    deb_d  = 1'b0;
    if (sync_q[1]) begin
      gap_d = '0;
      deb_d = is_real;
    end else if (!(&gap_q)) begin
      gap_d = gap_q + 1'b1;  // saturate so a long pause never looks short
    end
    if (gap_clr) begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      gap_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      gap_q  <= gap_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_pulse = deb_q;

endmodule

// File: rtl/dialer_digit_collector.sv
// Purpose: rotary-dialer front end; debounces rest/pulse contacts and collects N_DIGITS digits.
// Latency: commit strobe 1 cycle after the debounced rest contact closes.
// Backpressure: none; consumer must take digit_strobe/digit_value when presented.
// Ports: CLK, reset (sync, active-high), clear (start new number),
//        dialer_in_rest / dialer_pulses (raw contacts), all_dialed, n_dialed,
//        digits (digit k at [k*DIG_W +: DIG_W]), digit_strobe, digit_value,
//        range_err (sticky), deb_pulses (accepted pulse strobe).
module dialer_digit_collector
  import dialer_digit_collector_pkg::*;
#(
  parameter int N_DIGITS     = 7,
  parameter int DIG_W        = 4,
  parameter int MODE         = 0,
  parameter int REST_DEB_MSB = 19,
  parameter int PULSE_MSB    = 22,
  parameter int PULSE_DLY    = 19,
  parameter int TIMEOUT_MSB  = 27,
  localparam int NW          = $clog2(N_DIGITS + 1)
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      dialer_in_rest,
  input  logic                      dialer_pulses,
  output logic                      all_dialed,
  output logic [NW-1:0]             n_dialed,
  output logic [N_DIGITS*DIG_W-1:0] digits,
  output logic                      digit_strobe,
  output logic [DIG_W-1:0]          digit_value,
  output logic                      range_err,
  output logic                      deb_pulses
);

  logic rest_deb;
  logic deb_pulse;
  logic gap_clr;

  // The debounced rest level resets to "off rest": a dial already turning at
  // reset then produces no falling edge, and its return to rest lands in
  // S_IDLE where it is ignored instead of committing a half-counted digit.
  debounced_button #(
    .CNT_MSB (REST_DEB_MSB),
    .RST_VAL (1'b0)
  ) u_rest_deb (
    .clk     (CLK),
    .reset   (reset),
    .btn_in  (dialer_in_rest),
    .btn_out (rest_deb)
  );

  dialer_pulse_filter #(
    .PULSE_MSB (PULSE_MSB),
    .PULSE_DLY (PULSE_DLY)
  ) u_pulse (
    .clk       (CLK),
    .reset     (reset),
    .pulse_in  (dialer_pulses),
    .gap_clr   (gap_clr),
    .deb_pulse (deb_pulse)
  );

  state_t             state_q, state_d;
  logic               rest_prev_q, rest_prev_d;
  logic [NW-1:0]      n_q, n_d;
  logic [DIG_W-1:0]   dig_q [N_DIGITS];
  logic [DIG_W-1:0]   dig_d [N_DIGITS];
  logic               strobe_q, strobe_d;
  logic [DIG_W-1:0]   value_q, value_d;
  logic               err_q, err_d;
  logic               all_q, all_d;
  logic [TIMEOUT_MSB:0] tmo_q, tmo_d;

  logic               rest_fall, rest_rise, n_full;
  logic [DIG_W-1:0]   cur_dig, inc_dig, commit_val;
  logic               inc_err;
  logic               wr_en;
  logic [DIG_W-1:0]   wr_val;

  assign rest_fall = rest_prev_q & ~rest_deb;
  assign rest_rise = ~rest_prev_q & rest_deb;
  assign n_full    = (n_q == NW'(N_DIGITS));

  // Digit currently being dialed; reads as 0 once every slot is used.
  always_comb begin
    cur_dig = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (n_q == NW'(k)) cur_dig = dig_q[k];
    end
  end

  // Value after one more pulse, and whether that pulse is out of range.
  always_comb begin
    inc_dig    = cur_dig + 1'b1;
    inc_err    = 1'b0;
    commit_val = cur_dig;
    if (MODE == MODE_FACT) begin
      if (cur_dig > DIG_W'(n_q)) begin
        inc_dig = '0;
        inc_err = 1'b1;
      end
    end else begin
      if (cur_dig >= DIG_W'(DEC_ZERO_CODE)) begin
        inc_dig = cur_dig;
        inc_err = 1'b1;
      end
      if (cur_dig == DIG_W'(DEC_ZERO_CODE)) commit_val = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    rest_prev_d = rest_deb;
    n_d         = n_q;
    dig_d       = dig_q;
    strobe_d    = 1'b0;
    value_d     = value_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    gap_clr     = 1'b0;
    wr_en       = 1'b0;
    wr_val      = '0;

    case (state_q)
      S_IDLE: begin
        if (rest_fall && !n_full) begin
          state_d = S_DIAL;
          wr_en   = 1'b1;
          gap_clr = 1'b1;
        end
      end
      S_DIAL: begin
        // A pulse landing in the very cycle the dial returns to rest is
        // mechanically impossible, so the commit simply takes priority.
        if (rest_rise) begin
          state_d  = S_GAP;
          strobe_d = 1'b1;
          value_d  = commit_val;
          wr_en    = 1'b1;
          wr_val   = commit_val;
          n_d      = n_q + 1'b1;
          tmo_d    = '0;
        end else if (deb_pulse) begin
          wr_en  = 1'b1;
          wr_val = inc_dig;
          if (inc_err) err_d = 1'b1;
        end
      end
      S_GAP: begin
        tmo_d = tmo_q + 1'b1;
        if (n_full || tmo_q[TIMEOUT_MSB]) begin
          state_d = S_IDLE;
        end else if (rest_fall) begin
          state_d = S_DIAL;
          wr_en   = 1'b1;
          gap_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (n_q == NW'(k)) dig_d[k] = wr_val;
      end
    end

    // clear overrides everything above, including a commit in this cycle.
    if (clear) begin
      n_d      = '0;
      err_d    = 1'b0;
      strobe_d = 1'b0;
      tmo_d    = '0;
      for (int k = 0; k < N_DIGITS; k++) dig_d[k] = '0;
      if (rest_deb) begin
        state_d = S_IDLE;
        gap_clr = 1'b0;
      end else begin
        state_d = S_DIAL;
        gap_clr = 1'b1;
      end
    end

    all_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rest_prev_q <= 1'b0;
      n_q         <= '0;
      for (int k = 0; k < N_DIGITS; k++) dig_q[k] <= '0;
      strobe_q    <= 1'b0;
      value_q     <= '0;
      err_q       <= 1'b0;
      all_q       <= 1'b1;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rest_prev_q <= rest_prev_d;
      n_q         <= n_d;
      dig_q       <= dig_d;
      strobe_q    <= strobe_d;
      value_q     <= value_d;
      err_q       <= err_d;
      all_q       <= all_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    digits = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      digits[k*DIG_W +: DIG_W] = dig_q[k];
    end
  end

  assign all_dialed   = all_q;
  assign n_dialed     = n_q;
  assign digit_strobe = strobe_q;
  assign digit_value  = value_q;
  assign range_err    = err_q;
  assign deb_pulses   = deb_pulse;

endmodule

// File: tb/tb_dialer_digit_collector.sv
// Bench for dialer_digit_collector: one factorial-mode and one decimal-mode
// instance share the same contact stimulus; a reference model predicts each
// committed digit and the final number state for both.
module tb_dialer_digit_collector;

  localparam int N  = 7;
  localparam int DW = 4;
  localparam int NW = 3;

  logic clk = 1'b0;
  logic reset, clear, rest, pulses;

  logic          all_o    [2];
  logic [NW-1:0] n_o      [2];
  logic [N*DW-1:0] dig_o  [2];
  logic          strobe_o [2];
  logic [DW-1:0] value_o  [2];
  logic          err_o    [2];
  logic          deb_o    [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dialer_digit_collector #(
      .N_DIGITS(N), .DIG_W(DW), .MODE(g),
      .REST_DEB_MSB(3), .PULSE_MSB(6), .PULSE_DLY(4), .TIMEOUT_MSB(8)
    ) u_dut (
      .CLK(clk), .reset(reset), .clear(clear),
      .dialer_in_rest(rest), .dialer_pulses(pulses),
      .all_dialed(all_o[g]), .n_dialed(n_o[g]), .digits(dig_o[g]),
      .digit_strobe(strobe_o[g]), .digit_value(value_o[g]),
      .range_err(err_o[g]), .deb_pulses(deb_o[g])
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int vf; int vd; int n; } exp_t;
  exp_t sb_q[$];
  int   m_dig [2][N];
  int   m_err [2];
  int   m_n;
  int   deb_cnt [2];

  task automatic model_clear();
    m_n = 0;
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0;
      for (int k = 0; k < N; k++) m_dig[i][k] = 0;
    end
  endtask

  // p pulses dialed into the next free position
  task automatic model_digit(input int p);
    exp_t e;
    int k;
    if (m_n < N) begin
      k = m_n;
      m_dig[0][k] = p % (k + 2);
      if (p > k + 1) m_err[0] = 1;
      m_dig[1][k] = (p >= 10) ? 0 : p;
      if (p > 10) m_err[1] = 1;
      m_n++;
      e.vf = m_dig[0][k];
      e.vd = m_dig[1][k];
      e.n  = m_n;
      sb_q.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) if (deb_o[i]) deb_cnt[i]++;
    if (strobe_o[0] || strobe_o[1]) begin
      check("strobe_expected", int'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("strobe_fact", int'(strobe_o[0]), 1);
        check("strobe_dec", int'(strobe_o[1]), 1);
        check("value_fact", int'(value_o[0]), e.vf);
        check("value_dec", int'(value_o[1]), e.vd);
        check("n_at_strobe_fact", int'(n_o[0]), e.n);
        check("n_at_strobe_dec", int'(n_o[1]), e.n);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rest_to(input logic v);
    repeat ($urandom_range(0, 3)) begin
      rest = v;  tick($urandom_range(1, 3));
      rest = !v; tick($urandom_range(1, 3));
    end
    rest = v;
  endtask

  task automatic pulse(input bit glitch);
    pulses = 1'b1;
    tick($urandom_range(3, 8));
    if (glitch) begin
      repeat (3) begin
        pulses = 1'b0; tick($urandom_range(1, 4));
        pulses = 1'b1; tick($urandom_range(1, 4));
      end
    end
    pulses = 1'b0;
    tick($urandom_range(22, 40));
  endtask

  // glitch: 0 clean, 1 every pulse chatters, 2 random
  task automatic dial(input int p, input int glitch, input bit clear_at_rise);
    if (!clear_at_rise) model_digit(p);
    rest_to(1'b0);
    tick(40);
    for (int j = 0; j < p; j++)
      pulse(glitch == 1 || (glitch == 2 && $urandom_range(0, 1) == 1));
    rest_to(1'b1);
    if (clear_at_rise) begin
      // window brackets the debounced rest edge, so clear meets the commit
      tick(4);
      clear = 1'b1;
      tick(16);
      clear = 1'b0;
      model_clear();
    end
    tick(30);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    model_clear();
    tick(2);
  endtask

  task automatic check_status(input string tag, input int want_all);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_all_dialed"}, int'(all_o[i]), want_all);
      check({tag, "_n_dialed"}, int'(n_o[i]), m_n);
      check({tag, "_range_err"}, int'(err_o[i]), m_err[i]);
      for (int k = 0; k < N; k++)
        check({tag, "_digit"}, int'(dig_o[i][k*DW +: DW]), m_dig[i][k]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_all_dialed"}, int'(all_o[i]), 1);
      check({tag, "_n_dialed"}, int'(n_o[i]), 0);
      check({tag, "_digits"}, int'(dig_o[i]), 0);
      check({tag, "_strobe"}, int'(strobe_o[i]), 0);
      check({tag, "_value"}, int'(value_o[i]), 0);
      check({tag, "_range_err"}, int'(err_o[i]), 0);
      check({tag, "_deb"}, int'(deb_o[i]), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    reset = 1'b1; clear = 1'b0; rest = 1'b1; pulses = 1'b0;
    deb_cnt[0] = 0; deb_cnt[1] = 0;
    model_clear();
    tick(3);
    check_reset_vals("reset");
    reset = 1'b0;
    tick(20);

    // Factorial sweep: digit k gets k+1 pulses, the top of its legal range.
    for (int k = 0; k < N; k++) dial(k + 1, 0, 1'b0);
    check_status("full_number", 1);
    // A further dial with all slots used must be ignored.
    dial(3, 0, 1'b0);
    check_status("dial_when_full", 1);
    do_clear();
    check_status("after_clear", 1);

    // Contact chatter on every pulse.
    deb_cnt[0] = 0; deb_cnt[1] = 0;
    dial(5, 1, 1'b0);
    check("bounce_deb_count_fact", deb_cnt[0], 5);
    check("bounce_deb_count_dec", deb_cnt[1], 5);
    tick(300);
    check_status("bounce", 1);
    do_clear();

    // Factorial overflow on digit 0, then clear drops the sticky error.
    dial(3, 0, 1'b0);
    tick(300);
    check_status("fact_overflow", 1);
    do_clear();
    check_status("overflow_cleared", 1);

    // Decimal zero and decimal overflow, ending on the inter-digit timeout.
    dial(10, 0, 1'b0);
    check("gap_all_dialed_low_fact", int'(all_o[0]), 0);
    check("gap_all_dialed_low_dec", int'(all_o[1]), 0);
    dial(11, 0, 1'b0);
    tick(300);
    check_status("decimal_timeout", 1);
    do_clear();

    // clear landing on the commit edge.
    dial(4, 0, 1'b0);
    dial(2, 0, 1'b1);
    check_status("clear_at_rise", 1);

    // Randomised numbers.
    for (int r = 0; r < 4; r++) begin
      nd = $urandom_range(1, N);
      for (int d = 0; d < nd; d++) dial($urandom_range(0, 12), 2, 1'b0);
      if (nd < N) tick(300);
      check_status("random_number", 1);
      do_clear();
    end

    // Reset in the middle of a pulse train; the later return to rest must not commit.
    rest_to(1'b0);
    tick(40);
    pulse(1'b0);
    pulse(1'b0);
    pulses = 1'b1;
    reset = 1'b1;
    tick(2);
    check_reset_vals("mid_reset");
    reset = 1'b0;
    pulses = 1'b0;
    model_clear();
    tick(25);
    pulse(1'b0);
    pulse(1'b0);
    rest_to(1'b1);
    tick(40);
    check_status("after_mid_reset", 1);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
